// File: rtl/lowpass_ch_sched_if.sv
// lowpass_ch_sched_if: per-channel input streams and the single FIR-side stream of the scheduler
interface lowpass_ch_sched_if #(parameter int NUM_CH = 8);
  logic [NUM_CH*24-1:0] ch_tdata;
  logic [NUM_CH-1:0] ch_tvalid, ch_tready, ch_enable;
  logic [23:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, busy;
  logic [2:0] m_axis_tuser;
  modport master (
    output ch_tdata, ch_tvalid, ch_enable, m_axis_tready,
    input ch_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy
  );
  modport slave (
    input ch_tdata, ch_tvalid, ch_enable, m_axis_tready,
    output ch_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy
  );
endinterface

// File: rtl/lowpass_ch_sched.sv
// lowpass_ch_sched: per-channel FIFOs serialised round-robin onto one stream, channel index on tuser
module lowpass_ch_sched #(
  parameter int NUM_CH = 8,
  parameter int DEPTH  = 4
) (
  input logic s_axis_aclk,
  input logic s_axis_arstn,
  lowpass_ch_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [23:0] r_mem [NUM_CH][DEPTH];
  logic [AW-1:0] r_wp [NUM_CH];
  logic [AW-1:0] r_rp [NUM_CH];
  logic [CW-1:0] r_cnt [NUM_CH];
  logic [2:0] r_last, r_user;
  logic [23:0] r_data;
  logic r_valid, r_tlast;
  logic [NUM_CH-1:0] w_full, w_empty, w_push, w_pop, w_elig;
  logic [2:0] w_grant, w_hi;
  logic w_found, w_load;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_full[i] = r_cnt[i] == CW'(DEPTH);
      w_empty[i] = r_cnt[i] == '0;
    end
  end
  // ready comes only from registered occupancy, never from m_axis_tready
  assign bus.ch_tready = {NUM_CH{s_axis_arstn}} & bus.ch_enable & ~w_full;
  assign w_push = bus.ch_tvalid & bus.ch_tready;
  assign w_elig = bus.ch_enable & ~w_empty;
  assign w_load = !r_valid | bus.m_axis_tready;
  assign w_pop = {NUM_CH{w_load & w_found}} & (NUM_CH'(1) << w_grant);
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_hi = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.ch_enable[i]) w_hi = 3'(i);
    for (int i = 1; i <= NUM_CH; i++)
      if (!w_found && w_elig[(int'(r_last) + i) % NUM_CH]) begin
        w_found = 1'b1;
        w_grant = 3'((int'(r_last) + i) % NUM_CH);
      end
  end
  always_ff @(posedge s_axis_aclk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (w_push[i]) r_mem[i][r_wp[i]] <= bus.ch_tdata[24*i +: 24];
  end
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wp[i] <= '0;
        r_rp[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
        if (w_pop[i]) r_rp[i] <= r_rp[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  end
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_user <= '0;
      r_tlast <= 1'b0;
      r_last <= 3'(NUM_CH - 1);
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_data <= r_mem[w_grant][r_rp[w_grant]];
        r_user <= w_grant;
        r_tlast <= w_grant == w_hi;
        r_last <= w_grant;
      end
    end
  end
  assign bus.m_axis_tvalid = r_valid;
  assign bus.m_axis_tdata = r_data;
  assign bus.m_axis_tuser = r_user;
  assign bus.m_axis_tlast = r_tlast;
  assign bus.busy = r_valid | ~(&w_empty);
endmodule

// File: tb/tb_lowpass_ch_sched.sv
// tb_lowpass_ch_sched: queue-based reference model checked every cycle, plus directed literal checks
module tb_lowpass_ch_sched;
  localparam int N = 8;
  localparam int D = 4;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  lowpass_ch_sched_if #(.NUM_CH(N)) bus();
  lowpass_ch_sched #(.NUM_CH(N), .DEPTH(D)) dut (
    .s_axis_aclk(clk),
    .s_axis_arstn(rst_n),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  logic [23:0] mq [N][$];
  logic m_valid = 0;
  logic [23:0] m_data = 0;
  int m_user = 0;
  logic m_last = 0;
  int m_lg = N - 1;
  int g, hi;
  logic [N-1:0] pushm, exp_rdy;
  logic any_q;
  logic [23:0] rec_data[$];
  int rec_user[$];
  logic rec_last[$];
  logic [23:0] exp_full[5] = '{24'h0000AA, 24'd1, 24'd2, 24'd3, 24'd4};
  logic [23:0] exp_sim[4] = '{24'h0000A1, 24'h0000A2, 24'h0000A3, 24'h0000A4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push(input int c, input logic [23:0] d);
    bus.ch_tvalid[c] = 1'b1;
    bus.ch_tdata[24*c +: 24] = d;
    tick();
    bus.ch_tvalid[c] = 1'b0;
  endtask

  // reference: per-channel queues, round-robin search from the last grant, one output slot
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      m_valid = 0;
      m_data = 0;
      m_user = 0;
      m_last = 0;
      m_lg = N - 1;
    end else begin
      hi = -1;
      g = -1;
      for (int c = 0; c < N; c++) begin
        if (bus.ch_enable[c]) hi = c;
        pushm[c] = bus.ch_tvalid[c] && bus.ch_enable[c] && mq[c].size() < D;
      end
      if (!m_valid || bus.m_axis_tready) begin
        for (int k = 1; k <= N; k++)
          if (g < 0 && bus.ch_enable[(m_lg + k) % N] && mq[(m_lg + k) % N].size() > 0) g = (m_lg + k) % N;
        m_valid = g >= 0;
        if (g >= 0) begin
          m_data = mq[g].pop_front();
          m_user = g;
          m_last = g == hi;
          m_lg = g;
        end
      end
      for (int c = 0; c < N; c++)
        if (pushm[c]) mq[c].push_back(bus.ch_tdata[24*c +: 24]);
    end
  end

  always @(posedge clk)
    if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
      rec_data.push_back(bus.m_axis_tdata);
      rec_user.push_back(int'(bus.m_axis_tuser));
      rec_last.push_back(bus.m_axis_tlast);
    end

  always @(negedge clk) begin
    any_q = 0;
    for (int c = 0; c < N; c++) begin
      exp_rdy[c] = rst_n && bus.ch_enable[c] && mq[c].size() < D;
      if (mq[c].size() > 0) any_q = 1;
    end
    chk("m_tvalid", 32'(bus.m_axis_tvalid), 32'(m_valid));
    chk("m_tdata", 32'(bus.m_axis_tdata), 32'(m_data));
    chk("m_tuser", 32'(bus.m_axis_tuser), 32'(m_user));
    chk("m_tlast", 32'(bus.m_axis_tlast), 32'(m_last));
    chk("m_busy", 32'(bus.busy), 32'(m_valid || any_q));
    chk("m_ch_tready", 32'(bus.ch_tready), 32'(exp_rdy));
  end

  initial begin
    bus.ch_tdata = '0;
    bus.ch_tvalid = '0;
    bus.ch_enable = 8'h0F;
    bus.m_axis_tready = 1'b0;
    repeat (2) tick();
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ch_tready", 32'(bus.ch_tready), 0);
    rst_n = 1;
    push(3, 24'h000123);
    chk("lat_not_yet", 32'(bus.m_axis_tvalid), 0);
    tick();
    chk("first_tvalid", 32'(bus.m_axis_tvalid), 1);
    chk("first_tdata", 32'(bus.m_axis_tdata), 32'h000123);
    chk("first_tuser", 32'(bus.m_axis_tuser), 3);
    chk("first_tlast", 32'(bus.m_axis_tlast), 1);
    chk("first_busy", 32'(bus.busy), 1);
    bus.m_axis_tready = 1'b1;
    tick();
    chk("first_done_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("first_done_busy", 32'(bus.busy), 0);

    bus.ch_enable = 8'hFF;
    bus.m_axis_tready = 1'b0;
    rec_data.delete(); rec_user.delete(); rec_last.delete();
    push(0, 24'h0000AA);
    tick();
    for (int i = 1; i <= 4; i++) push(1, 24'(i));
    chk("full_rdy_low", 32'(bus.ch_tready[1]), 0);
    bus.ch_tvalid[1] = 1'b1;
    bus.ch_tdata[24 +: 24] = 24'd5;
    repeat (2) tick();
    chk("full_rdy_held", 32'(bus.ch_tready[1]), 0);
    bus.m_axis_tready = 1'b1;
    tick();
    chk("full_rdy_back", 32'(bus.ch_tready[1]), 1);
    bus.ch_tvalid[1] = 1'b0;
    repeat (6) tick();
    chk("full_n", 32'(rec_data.size()), 5);
    for (int i = 0; i < 5 && i < rec_data.size(); i++) begin
      chk("full_data", 32'(rec_data[i]), 32'(exp_full[i]));
      chk("full_user", 32'(rec_user[i]), i == 0 ? 0 : 1);
    end

    bus.m_axis_tready = 1'b0;
    rec_data.delete(); rec_user.delete(); rec_last.delete();
    push(0, 24'h0000A1);
    push(0, 24'h0000A2);
    push(0, 24'h0000A3);
    bus.m_axis_tready = 1'b1;
    bus.ch_tvalid[0] = 1'b1;
    bus.ch_tdata[0 +: 24] = 24'h0000A4;
    tick();
    bus.ch_tvalid[0] = 1'b0;
    bus.m_axis_tready = 1'b0;
    tick();
    bus.m_axis_tready = 1'b1;
    repeat (5) tick();
    chk("sim_n", 32'(rec_data.size()), 4);
    for (int i = 0; i < 4 && i < rec_data.size(); i++) chk("sim_data", 32'(rec_data[i]), 32'(exp_sim[i]));

    bus.m_axis_tready = 1'b0;
    rec_data.delete(); rec_user.delete(); rec_last.delete();
    push(2, 24'h0000B1);
    push(2, 24'h0000B2);
    push(2, 24'h0000B3);
    bus.ch_enable = 8'hFB;
    #1;
    chk("en_rdy_drop", 32'(bus.ch_tready[2]), 0);
    bus.m_axis_tready = 1'b1;
    repeat (4) tick();
    chk("en_idle", 32'(bus.m_axis_tvalid), 0);
    chk("en_n1", 32'(rec_data.size()), 1);
    if (rec_data.size() > 0) begin
      chk("en_b1", 32'(rec_data[0]), 32'h0000B1);
      chk("en_b1_last", 32'(rec_last[0]), 0);
    end
    bus.ch_enable = 8'h07;
    repeat (4) tick();
    chk("en_n3", 32'(rec_data.size()), 3);
    for (int i = 1; i < 3 && i < rec_data.size(); i++) begin
      chk("en_data", 32'(rec_data[i]), 32'h0000B1 + 32'(i));
      chk("en_last", 32'(rec_last[i]), 1);
    end

    rst_n = 0;
    tick();
    rst_n = 1;
    bus.ch_enable = 8'hFF;
    bus.m_axis_tready = 1'b0;
    for (int c = 0; c < N; c++) bus.ch_tdata[24*c +: 24] = 24'(c * 32'h10000 + 1);
    bus.ch_tvalid = 8'hFF;
    rec_data.delete(); rec_user.delete(); rec_last.delete();
    for (int p = 0; p < 16; p++) begin
      repeat (128) tick();
      bus.m_axis_tready = 1'b1;
      tick();
      bus.m_axis_tready = 1'b0;
    end
    chk("rr_n", 32'(rec_data.size()), 16);
    for (int i = 0; i < 16 && i < rec_data.size(); i++) begin
      chk("rr_user", 32'(rec_user[i]), 32'(i % 8));
      chk("rr_data", 32'(rec_data[i]), 32'((i % 8) * 32'h10000 + 1));
      chk("rr_last", 32'(rec_last[i]), 32'(i % 8 == 7));
    end

    rst_n = 0;
    bus.ch_tvalid = '0;
    #1;
    chk("mid_rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("mid_rst_tdata", 32'(bus.m_axis_tdata), 0);
    chk("mid_rst_tuser", 32'(bus.m_axis_tuser), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_rdy", 32'(bus.ch_tready), 0);
    tick();
    rst_n = 1;
    bus.m_axis_tready = 1'b1;
    rec_data.delete(); rec_user.delete(); rec_last.delete();
    repeat (5) tick();
    chk("mid_rst_stale", 32'(rec_data.size()), 0);
    chk("mid_rst_idle", 32'(bus.busy), 0);

    for (int i = 0; i < 3000; i++) begin
      bus.ch_tvalid = N'($urandom);
      for (int c = 0; c < N; c++) bus.ch_tdata[24*c +: 24] = 24'($urandom);
      bus.m_axis_tready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 49) == 0) bus.ch_enable = N'($urandom);
      if ($urandom_range(0, 299) == 0) bus.ch_enable = '0;
      tick();
    end
    bus.ch_tvalid = '0;
    bus.ch_enable = 8'hFF;
    bus.m_axis_tready = 1'b1;
    repeat (50) tick();
    chk("drain_busy", 32'(bus.busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
